// File: rtl/mppt_pkg.sv
// Shared definitions for the perturb-and-observe MPPT controller:
// FSM state encoding, default widths and the power-width helper.
package mppt_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DUTY_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_REQ    = 3'd2,
    ST_CALC   = 3'd3,
    ST_DECIDE = 3'd4
  } state_t;

  function automatic int power_width(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/duty_sat_step.sv
// Combinational duty perturbation: adds or subtracts one step with one bit of
// headroom, then saturates to [DUTY_MIN, DUTY_MAX] and flags a clamp event.
module duty_sat_step import mppt_pkg::*; #(
  parameter int DUTY_W    = DEF_DUTY_W,
  parameter int DUTY_STEP = 4,
  parameter int DUTY_MIN  = 16,
  parameter int DUTY_MAX  = 240
) (
  input  logic [DUTY_W-1:0] duty_in,
  input  logic              up,
  output logic [DUTY_W-1:0] next_duty,
  output logic              clamp_hit
);

  localparam logic [DUTY_W:0] STEP    = (DUTY_W+1)'(DUTY_STEP);
  localparam logic [DUTY_W:0] LO      = (DUTY_W+1)'(DUTY_MIN);
  localparam logic [DUTY_W:0] HI      = (DUTY_W+1)'(DUTY_MAX);
  localparam logic [DUTY_W:0] LO_PLUS = LO + STEP;

  logic [DUTY_W:0] ext;
  logic [DUTY_W:0] sum;

  // Down-step clamp is judged before subtracting so an underflow wrap cannot
  // masquerade as an in-range value.
  always_comb begin
    ext       = {1'b0, duty_in};
    sum       = up ? (ext + STEP) : (ext - STEP);
    clamp_hit = up ? (sum > HI) : (ext < LO_PLUS);
    next_duty = sum[DUTY_W-1:0];
    if (clamp_hit) begin
      next_duty = up ? HI[DUTY_W-1:0] : LO[DUTY_W-1:0];
    end
  end

endmodule

// File: rtl/mppt_po_controller.sv
// Perturb-and-observe MPPT controller: settles, requests a V/I sample,
// computes power and steps the duty setpoint toward the power maximum.
module mppt_po_controller import mppt_pkg::*; #(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int DUTY_W        = DEF_DUTY_W,
  parameter int DUTY_INIT     = 128,
  parameter int DUTY_STEP     = 4,
  parameter int DUTY_MIN      = 16,
  parameter int DUTY_MAX      = 240,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                sample_req,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   volt_in,
  input  logic [DATA_W-1:0]   curr_in,
  output logic [DUTY_W-1:0]   duty,
  output logic                duty_valid,
  output logic                dir,
  output logic [2*DATA_W-1:0] power,
  output logic                busy
);

  localparam int PW    = power_width(DATA_W);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [DUTY_W-1:0] DUTY_RST    = DUTY_W'(DUTY_INIT);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [PW-1:0]     prev_power_reg;
  logic              first_reg;
  logic [DATA_W-1:0] volt_reg;
  logic [DATA_W-1:0] curr_reg;

  logic [PW-1:0]     volt_ext;
  logic [PW-1:0]     curr_ext;
  logic              step_up;
  logic              do_step;
  logic [DUTY_W-1:0] next_duty;
  logic              clamp_hit;

  assign volt_ext = {{(PW-DATA_W){1'b0}}, volt_reg};
  assign curr_ext = {{(PW-DATA_W){1'b0}}, curr_reg};

  // First decision after (re)enable steps blindly; otherwise a drop in power
  // reverses direction and equal power holds the setpoint.
  always_comb begin
    step_up = dir;
    do_step = first_reg || (power != prev_power_reg);
    if (!first_reg && (power < prev_power_reg)) begin
      step_up = ~dir;
    end
  end

  duty_sat_step #(
    .DUTY_W    (DUTY_W),
    .DUTY_STEP (DUTY_STEP),
    .DUTY_MIN  (DUTY_MIN),
    .DUTY_MAX  (DUTY_MAX)
  ) u_step (
    .duty_in   (duty),
    .up        (step_up),
    .next_duty (next_duty),
    .clamp_hit (clamp_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      prev_power_reg <= '0;
      first_reg      <= 1'b1;
      volt_reg       <= '0;
      curr_reg       <= '0;
      duty           <= DUTY_RST;
      dir            <= 1'b1;
      sample_req     <= 1'b0;
      duty_valid     <= 1'b0;
      power          <= '0;
      busy           <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (!en) begin
        state_reg  <= ST_IDLE;
        sample_req <= 1'b0;
        busy       <= 1'b0;
        first_reg  <= 1'b1;
      end else begin
        unique case (state_reg)
          ST_IDLE: begin
            state_reg <= ST_SETTLE;
            cnt_reg   <= SETTLE_LOAD;
            busy      <= 1'b1;
          end
          ST_SETTLE: begin
            if (cnt_reg == '0) begin
              state_reg  <= ST_REQ;
              sample_req <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
          end
          ST_REQ: begin
            if (sample_valid) begin
              volt_reg   <= volt_in;
              curr_reg   <= curr_in;
              sample_req <= 1'b0;
              state_reg  <= ST_CALC;
            end
          end
          ST_CALC: begin
            power     <= volt_ext * curr_ext;
            state_reg <= ST_DECIDE;
          end
          ST_DECIDE: begin
            // A clamp leaves duty on the bound and turns the direction around.
            if (do_step) begin
              duty <= next_duty;
              dir  <= step_up ^ clamp_hit;
            end
            prev_power_reg <= power;
            first_reg      <= 1'b0;
            duty_valid     <= 1'b1;
            state_reg      <= ST_SETTLE;
            cnt_reg        <= SETTLE_LOAD;
          end
          default: begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mppt_po_controller.sv
// Scoreboard bench for mppt_po_controller: a driver answers sample requests
// and feeds a behavioural P&O model; a monitor checks every duty_valid pulse.
module tb_mppt_po_controller;

  localparam int STEP   = 4;
  localparam int DMIN   = 16;
  localparam int DMAX   = 240;
  localparam int DINIT  = 128;
  localparam int SETTLE = 64;

  logic        clk = 1'b0;
  logic        rst, en, sample_valid;
  logic [7:0]  volt_in, curr_in;
  logic        sample_req, duty_valid, dir, busy;
  logic [7:0]  duty;
  logic [15:0] power;

  always #5 clk = ~clk;

  mppt_po_controller dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sample_req   (sample_req),
    .sample_valid (sample_valid),
    .volt_in      (volt_in),
    .curr_in      (curr_in),
    .duty         (duty),
    .duty_valid   (duty_valid),
    .dir          (dir),
    .power        (power),
    .busy         (busy)
  );

  typedef struct {
    int p;
    int duty;
    int dir;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_duty, m_dir, m_prev, m_first;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_duty = DINIT; m_dir = 1; m_prev = 0; m_first = 1;
  endtask

  // Reference P&O rule: compare to previous power, pick a direction, step,
  // saturate at the bounds and turn around when saturated.
  task automatic model_sample(input int v, input int i, input int acc);
    int p, up, n;
    bit stepit;
    p = v * i;
    stepit = 1;
    up = m_dir;
    if (!m_first && p < m_prev) up = 1 - m_dir;
    else if (!m_first && p == m_prev) stepit = 0;
    if (stepit) begin
      n = up ? m_duty + STEP : m_duty - STEP;
      if (n > DMAX)      begin m_duty = DMAX; m_dir = 1 - up; end
      else if (n < DMIN) begin m_duty = DMIN; m_dir = 1 - up; end
      else               begin m_duty = n;    m_dir = up;     end
    end
    m_prev = p;
    m_first = 0;
    sb.push_back('{p, m_duty, m_dir, acc + 2});
  endtask

  task automatic wait_req(output bit ok);
    int w = 0;
    while (sample_req !== 1'b1 && w < 400) begin
      sample_valid = 1'($urandom_range(0, 1));
      volt_in = 8'($urandom);
      curr_in = 8'($urandom);
      @(negedge clk);
      w++;
    end
    sample_valid = 1'b0;
    ok = (sample_req === 1'b1);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL req_timeout actual=0 expected=1 (cycle %0d)", cyc);
    end
  endtask

  task automatic do_sample(input int v, input int i, input int delay);
    bit ok;
    wait_req(ok);
    if (ok) begin
      repeat (delay) @(negedge clk);
      check("req_held", int'(sample_req), 1);
      volt_in = 8'(v);
      curr_in = 8'(i);
      sample_valid = 1'b1;
      model_sample(v, i, cyc + 1);
      $display("sample v=%0d i=%0d exp_power=%0d exp_duty=%0d exp_dir=%0d", v, i, v * i, m_duty, m_dir);
      @(negedge clk);
      sample_valid = 1'b0;
      check("req_drop", int'(sample_req), 0);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (duty_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_duty_valid actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        $display("decision power=%0d duty=%0d dir=%0d", power, duty, dir);
        check("power", int'(power), e.p);
        check("duty", int'(duty), e.duty);
        check("dir", int'(dir), e.dir);
        check("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    bit ok;
    int e_cyc, w;
    rst = 1'b1; en = 1'b0; sample_valid = 1'b0; volt_in = '0; curr_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_duty", int'(duty), DINIT);
    check("rst_dir", int'(dir), 1);
    check("rst_req", int'(sample_req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_power", int'(power), 0);
    rst = 1'b0; en = 1'b1;

    // Directed tracking and equal-power sequence.
    do_sample(25, 10, 2);
    do_sample(25, 12, 0);
    do_sample(25, 11, 5);
    do_sample(20, 10, 1);
    do_sample(20, 10, 3);

    // Strictly rising power drives duty into the upper then the lower clamp.
    for (int k = 0; k < 96; k++) do_sample(40 + 2 * k, 200, int'($urandom_range(0, 2)));

    // Random samples; small operands make equal-power decisions common.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) do_sample(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
      else do_sample(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    end

    // Enable drop while requesting; idle sample_valid must be ignored.
    wait_req(ok);
    en = 1'b0;
    @(negedge clk);
    check("dis_req", int'(sample_req), 0);
    check("dis_busy", int'(busy), 0);
    check("dis_duty", int'(duty), m_duty);
    check("dis_dir", int'(dir), m_dir);
    for (int k = 0; k < 5; k++) begin
      sample_valid = 1'b1; volt_in = 8'($urandom); curr_in = 8'($urandom);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    check("idle_busy", int'(busy), 0);
    en = 1'b1;
    m_first = 1;
    do_sample(1, 1, 0);
    do_sample(2, 1, 1);

    // Asynchronous reset in the middle of a request.
    wait_req(ok);
    #2 rst = 1'b1;
    #1;
    check("arst_duty", int'(duty), DINIT);
    check("arst_dir", int'(dir), 1);
    check("arst_req", int'(sample_req), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_power", int'(power), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    w = 0;
    while (busy !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    e_cyc = cyc;
    wait_req(ok);
    check("settle_len", cyc - e_cyc, SETTLE);
    do_sample(30, 30, 0);

    w = 0;
    while (sb.size() != 0 && w < 20) begin @(negedge clk); w++; end
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
